// File: rtl/router_fsm_np_if.sv
// Handshake and status bundle between the router FSM, the input register
// block and the output FIFO synchroniser. slave = the FSM, master = the
// surrounding datapath (or a testbench standing in for it).
interface router_fsm_np_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2,
    parameter int CNT_W     = 8
);
    logic                 pkt_valid;
    logic                 parity_done;
    logic                 low_pkt_valid;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] soft_reset;
    logic [ADDR_W-1:0]    data_in;

    logic                 busy;
    logic                 detect_add;
    logic                 lfd_state;
    logic                 ld_state;
    logic                 laf_state;
    logic                 full_state;
    logic                 write_enb_reg;
    logic                 rst_int_reg;
    logic                 drop_state;
    logic [ADDR_W-1:0]    dest_port;
    logic [CNT_W-1:0]     drop_cnt;

    modport slave (
        input  pkt_valid, parity_done, low_pkt_valid, fifo_full,
               fifo_empty, soft_reset, data_in,
        output busy, detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, drop_state, dest_port, drop_cnt
    );

    modport master (
        output pkt_valid, parity_done, low_pkt_valid, fifo_full,
               fifo_empty, soft_reset, data_in,
        input  busy, detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, drop_state, dest_port, drop_cnt
    );
endinterface

// File: rtl/router_fsm_np.sv
// 1xN router controller: header decode, payload load, full stalls, parity
// check, and silent drop of packets addressed beyond NUM_PORTS.
// All outputs are registered alongside the state, so they are a pure
// function of the current state (no input-to-output paths).
module router_fsm_np #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2,
    parameter int CNT_W     = 8
) (
    input  logic           clock,
    input  logic           reset,
    router_fsm_np_if.slave bus
);
    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        FIFO_FULL_STATE    = 4'd3,
        LOAD_AFTER_FULL    = 4'd4,
        LOAD_PARITY        = 4'd5,
        CHECK_PARITY_ERROR = 4'd6,
        WAIT_TILL_EMPTY    = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    // Flag vector bit order: busy, detect_add, lfd, ld, laf, full, wen, rst_int, drop
    localparam int SPAN = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] NP_LIM = (ADDR_W + 1)'(NUM_PORTS);

    state_t            state;
    state_t            nxt;
    logic [8:0]        flags;
    logic [ADDR_W-1:0] dest_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SPAN-1:0]   empty_ext;
    logic [SPAN-1:0]   sreset_ext;
    logic              addr_ok;

    // Output flags for a given state; any unknown encoding reads as idle decode.
    function automatic logic [8:0] decode_flags(input state_t s);
        case (s)
            DECODE_ADDRESS:     decode_flags = 9'b010000000;
            LOAD_FIRST_DATA:    decode_flags = 9'b101000000;
            LOAD_DATA:          decode_flags = 9'b000100100;
            FIFO_FULL_STATE:    decode_flags = 9'b100001000;
            LOAD_AFTER_FULL:    decode_flags = 9'b100010100;
            LOAD_PARITY:        decode_flags = 9'b100000100;
            CHECK_PARITY_ERROR: decode_flags = 9'b100000010;
            WAIT_TILL_EMPTY:    decode_flags = 9'b100000000;
            DROP_PACKET:        decode_flags = 9'b000000001;
            default:            decode_flags = 9'b010000000;
        endcase
    endfunction

    // Pad per-port flags to the full address span so any dest/data_in index is in range.
    always_comb begin
        empty_ext                   = '0;
        sreset_ext                  = '0;
        empty_ext[NUM_PORTS-1:0]    = bus.fifo_empty;
        sreset_ext[NUM_PORTS-1:0]   = bus.soft_reset;
    end

    assign addr_ok = ({1'b0, bus.data_in} < NP_LIM);

    // Next-state logic; soft reset of the selected port aborts any active packet.
    always_comb begin
        nxt = state;
        case (state)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid) begin
                    if (!addr_ok)                    nxt = DROP_PACKET;
                    else if (empty_ext[bus.data_in]) nxt = LOAD_FIRST_DATA;
                    else                             nxt = WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY:    if (empty_ext[dest_q]) nxt = LOAD_FIRST_DATA;
            LOAD_FIRST_DATA:    nxt = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full)       nxt = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) nxt = LOAD_PARITY;
            end
            FIFO_FULL_STATE:    if (!bus.fifo_full) nxt = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)        nxt = DECODE_ADDRESS;
                else if (bus.low_pkt_valid) nxt = LOAD_PARITY;
                else                        nxt = LOAD_DATA;
            end
            LOAD_PARITY:        nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            DROP_PACKET:        if (!bus.pkt_valid) nxt = DECODE_ADDRESS;
            default:            nxt = DECODE_ADDRESS;
        endcase
        if (state != DECODE_ADDRESS && sreset_ext[dest_q])
            nxt = DECODE_ADDRESS;
    end

    // State, registered flags, latched destination and saturating drop counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= DECODE_ADDRESS;
            flags  <= decode_flags(DECODE_ADDRESS);
            dest_q <= '0;
            cnt_q  <= '0;
        end else begin
            state <= nxt;
            flags <= decode_flags(nxt);
            if (state == DECODE_ADDRESS && bus.pkt_valid) begin
                if (addr_ok)
                    dest_q <= bus.data_in;
                else if (cnt_q != {CNT_W{1'b1}})
                    cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.busy          = flags[8];
    assign bus.detect_add    = flags[7];
    assign bus.lfd_state     = flags[6];
    assign bus.ld_state      = flags[5];
    assign bus.laf_state     = flags[4];
    assign bus.full_state    = flags[3];
    assign bus.write_enb_reg = flags[2];
    assign bus.rst_int_reg   = flags[1];
    assign bus.drop_state    = flags[0];
    assign bus.dest_port     = dest_q;
    assign bus.drop_cnt      = cnt_q;
endmodule

// File: doc/router_fsm_np.md
Name: router_fsm_np

Overview:
- Parametrised successor to the 1x3 router controller FSM: sequences packet header decode, payload load, full stalls and parity check for a 1xN router.
- Sits between the input register block (which it drives with lfd/ld/laf/full/rst_int strobes) and the N output FIFOs plus the synchroniser (which supplies fifo_empty, fifo_full and soft_reset).
- New relative to the 3-port version:
  - port count and address width are parameters;
  - out-of-range destination addresses are detected and the packet is silently dropped;
  - the latched destination is exported;
  - dropped packets are counted.

Parameters:
- NUM_PORTS, 3, number of output ports/FIFOs; legal range 2..2**ADDR_W.
- ADDR_W, 2, width of the header destination field data_in.
- CNT_W, 8, width of the saturating dropped-packet counter.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pkt_valid  input  1  packet in progress on the input bus.
- parity_done  input  1  parity byte has been written (from register block).
- low_pkt_valid  input  1  pkt_valid fell while stalled (from register block).
- fifo_full  input  1  full flag of the currently selected FIFO (from synchroniser).
- fifo_empty  input  NUM_PORTS  per-port FIFO empty flags.
- soft_reset  input  NUM_PORTS  per-port timeout soft resets.
- data_in  input  ADDR_W  header destination field (data bits [ADDR_W-1:0]).
- busy  output  1  stall request to the packet source.
- detect_add  output  1  in DECODE_ADDRESS.
- lfd_state  output  1  in LOAD_FIRST_DATA.
- ld_state  output  1  in LOAD_DATA.
- laf_state  output  1  in LOAD_AFTER_FULL.
- full_state  output  1  in FIFO_FULL_STATE.
- write_enb_reg  output  1  FIFO write enable for payload/parity.
- rst_int_reg  output  1  in CHECK_PARITY_ERROR.
- drop_state  output  1  in DROP_PACKET.
- dest_port  output  ADDR_W  latched destination of current packet.
- drop_cnt  output  CNT_W  number of packets dropped, saturating.

Behaviour:

States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY, DROP_PACKET.

Reset (reset=1 at a rising edge):
- state goes to DECODE_ADDRESS; dest_port=0; drop_cnt=0.
- Resulting outputs: detect_add=1, all other 1-bit outputs 0.

Priority per edge: reset > soft_reset[dest_port] (any state except DECODE_ADDRESS, which then goes to DECODE_ADDRESS) > normal transitions.
- soft_reset of a non-selected port is ignored.

Transitions from DECODE_ADDRESS:
- pkt_valid & data_in>=NUM_PORTS -> DROP_PACKET; drop_cnt += 1, saturating at all-ones.
- pkt_valid & data_in<NUM_PORTS & fifo_empty[data_in] -> LOAD_FIRST_DATA.
- pkt_valid & data_in<NUM_PORTS & !fifo_empty[data_in] -> WAIT_TILL_EMPTY.
- else stay.
- dest_port loads data_in on any edge leaving DECODE_ADDRESS with a valid address; it holds otherwise.

Transitions from the other states:
- WAIT_TILL_EMPTY: fifo_empty[dest_port] -> LOAD_FIRST_DATA; else stay.
- LOAD_FIRST_DATA: unconditionally -> LOAD_DATA after 1 cycle.
- LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
- LOAD_PARITY: unconditionally -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- DROP_PACKET: pkt_valid -> stay; !pkt_valid (the parity byte cycle) -> DECODE_ADDRESS. No FIFO writes, no stall.

Outputs (Moore, decoded from the state register only, no input paths):
- busy=1 in LOAD_FIRST_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY; 0 in DECODE_ADDRESS, LOAD_DATA, DROP_PACKET.
- write_enb_reg=1 in LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY.
- All other state flags are one-hot per their state.

Boundary and timing rules:
- Header decode to first write: 1 cycle (DECODE_ADDRESS -> LOAD_FIRST_DATA) when the FIFO is empty.
- Minimum packet (header, 1 payload, parity) returns to DECODE_ADDRESS in 5 cycles.
- Unknown or X-free illegal state encodings recover to DECODE_ADDRESS.
- drop_cnt saturates; it never wraps.

Test Plan:
1. NUM_PORTS=3: reset, then pkt_valid=1, data_in=1, fifo_empty=3'b010 -> DECODE, LFD, LD on consecutive cycles; busy=1 only in LFD; dest_port=1. Drop pkt_valid -> LOAD_PARITY, CHECK_PARITY_ERROR, DECODE_ADDRESS.
2. data_in=0, fifo_empty[0]=0 for 3 cycles, then 1 -> WAIT_TILL_EMPTY held 3 cycles with busy=1, then LOAD_FIRST_DATA.
3. In LOAD_DATA assert fifo_full for 2 cycles -> FIFO_FULL_STATE, write_enb_reg=0, busy=1. Release -> LOAD_AFTER_FULL:
   - with low_pkt_valid=1 -> LOAD_PARITY;
   - rerun with parity_done=1 -> DECODE_ADDRESS.
4. data_in=3 (NUM_PORTS=3), pkt_valid=1 for 4 cycles -> DROP_PACKET with drop_state=1, busy=0, write_enb_reg=0; drop_cnt 0 -> 1; back to DECODE when pkt_valid=0. Repeat with CNT_W=2 and 5 drops -> drop_cnt saturates at 3.
5. In FIFO_FULL_STATE for port 0: soft_reset=3'b010 -> no effect; soft_reset=3'b001 -> DECODE_ADDRESS next edge. Separately, assert reset mid-LOAD_DATA -> DECODE_ADDRESS, dest_port=0, drop_cnt=0.
6. NUM_PORTS=4, ADDR_W=2: route to port 3 with fifo_empty=4'b1000 -> LOAD_FIRST_DATA, dest_port=3, no drop.
